// File: rtl/xor_share_pkg.sv
// Shared types, constants and helpers for the xor_share_arbiter slice.
package xor_share_pkg;

  localparam int unsigned XS_CNT_W = 16;
  localparam logic [XS_CNT_W-1:0] XS_CNT_MAX = {XS_CNT_W{1'b1}};

  // Result register occupancy
  typedef enum logic {
    XS_EMPTY = 1'b0,
    XS_FULL  = 1'b1
  } xs_state_e;

  // Index width for n requesters, never narrower than one bit
  function automatic int unsigned xs_idw(input int unsigned n);
    return (n <= 32'd2) ? 32'd1 : 32'($clog2(n));
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_pick
  import xor_share_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  // Scan NREQ positions starting at ptr, keep the first hit
  always_comb begin
    logic [IDW-1:0] j;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      j = IDW'((32'(ptr) + k) % NREQ);
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = j;
      end
    end
  end

endmodule

// File: rtl/xor_share_arbiter.sv
// Round-robin arbiter sharing one registered XOR stage among NREQ requesters.
// Optional per-requester saturating grant counters: define XOR_SHARE_ARB_STATS_EN.
module xor_share_arbiter
  import xor_share_pkg::*;
#(
  parameter  int unsigned NREQ = 4,
  parameter  int unsigned W    = 8,
  localparam int unsigned IDW  = xs_idw(NREQ)
) (
  input  logic              clk,
  input  logic              areset_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [W-1:0]      res_data,
  output logic [IDW-1:0]    res_id
`ifdef XOR_SHARE_ARB_STATS_EN
  ,
  output logic [NREQ*XS_CNT_W-1:0] grant_cnt
`endif
);

  xs_state_e       state_q, state_d;
  logic            slot_free;
  logic [NREQ-1:0] pick_gnt;
  logic [IDW-1:0]  pick_idx;
  logic            pick_any;
  logic [IDW-1:0]  ptr_q;
  logic [W-1:0]    xor_c;

  assign slot_free = (state_q == XS_EMPTY) || res_ready;

  rr_pick #(
    .NREQ(NREQ),
    .IDW (IDW)
  ) u_pick (
    .req(req_valid & {NREQ{slot_free}}),
    .ptr(ptr_q),
    .gnt(pick_gnt),
    .idx(pick_idx),
    .any(pick_any)
  );

  // Occupancy state register
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) state_q <= XS_EMPTY;
    else           state_q <= state_d;
  end

  // Next occupancy: a grant refills, a drain without grant empties
  always_comb begin
    state_d = state_q;
    if (pick_any)       state_d = XS_FULL;
    else if (res_ready) state_d = XS_EMPTY;
  end

  // Handshake outputs; ready is forced low while reset is asserted
  always_comb begin
    req_ready = pick_gnt & {NREQ{areset_n}};
    res_valid = (state_q == XS_FULL);
  end

  // XOR of the selected lane's operand pair
  always_comb begin
    xor_c = req_a[32'(pick_idx)*W +: W] ^ req_b[32'(pick_idx)*W +: W];
  end

  // Result payload and round-robin pointer update only on a grant
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      res_data <= '0;
      res_id   <= '0;
      ptr_q    <= '0;
    end else if (pick_any) begin
      res_data <= xor_c;
      res_id   <= pick_idx;
      ptr_q    <= IDW'((32'(pick_idx) + 32'd1) % NREQ);
    end
  end

`ifdef XOR_SHARE_ARB_STATS_EN
  logic [XS_CNT_W-1:0] cnt_q [NREQ];

  // Saturating grant counters, one per requester
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      for (int unsigned i = 0; i < NREQ; i++) cnt_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (pick_gnt[i] && (cnt_q[i] != XS_CNT_MAX)) cnt_q[i] <= cnt_q[i] + 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NREQ; g++) begin : g_cnt
    assign grant_cnt[g*XS_CNT_W +: XS_CNT_W] = cnt_q[g];
  end
`endif

endmodule

// File: tb/tb_xor_share_arbiter.sv
// Directed, table-driven bench for xor_share_arbiter (NREQ=4, W=8).
module tb_xor_share_arbiter;

  logic        clk;
  logic        areset_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        res_valid;
  logic        res_ready;
  logic [7:0]  res_data;
  logic [1:0]  res_id;
`ifdef XOR_SHARE_ARB_STATS_EN
  logic [63:0] grant_cnt;
`endif

  int total;
  int bad;

  typedef struct {
    logic [3:0]  v;
    logic [31:0] a;
    logic [31:0] b;
    logic        rr;
    logic [3:0]  er;
    logic        ev;
    logic [7:0]  ed;
    logic [1:0]  eid;
  } vec_t;

  vec_t tv[$];

  localparam logic [31:0] A  = 32'h44332211;
  localparam logic [31:0] B  = 32'h0F0F0F0F;
  localparam logic [31:0] SA = 32'h00A50000;
  localparam logic [31:0] SB = 32'h000F0000;

  xor_share_arbiter #(.NREQ(4), .W(8)) dut (
    .clk      (clk),
    .areset_n (areset_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a    (req_a),
    .req_b    (req_b),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_data (res_data),
    .res_id   (res_id)
`ifdef XOR_SHARE_ARB_STATS_EN
    ,
    .grant_cnt(grant_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] v, input logic [31:0] a, input logic [31:0] b,
                              input logic rr, input logic [3:0] er, input logic ev,
                              input logic [7:0] ed, input logic [1:0] eid);
    vec_t t;
    t.v = v; t.a = a; t.b = b; t.rr = rr;
    t.er = er; t.ev = ev; t.ed = ed; t.eid = eid;
    return t;
  endfunction

  initial begin
    total = 0;
    bad   = 0;

    // Fairness from reset: 0,1,2,3,0,1,2,3
    for (int r = 0; r < 2; r++) begin
      tv.push_back(mk(4'hF, A, B, 1'b1, 4'b0001, 1'b1, 8'h1E, 2'd0));
      tv.push_back(mk(4'hF, A, B, 1'b1, 4'b0010, 1'b1, 8'h2D, 2'd1));
      tv.push_back(mk(4'hF, A, B, 1'b1, 4'b0100, 1'b1, 8'h3C, 2'd2));
      tv.push_back(mk(4'hF, A, B, 1'b1, 4'b1000, 1'b1, 8'h4B, 2'd3));
    end
    // Wrap and skip: only 1 and 3 valid after last grant to 3
    for (int r = 0; r < 2; r++) begin
      tv.push_back(mk(4'b1010, A, B, 1'b1, 4'b0010, 1'b1, 8'h2D, 2'd1));
      tv.push_back(mk(4'b1010, A, B, 1'b1, 4'b1000, 1'b1, 8'h4B, 2'd3));
    end
    // Single lane 2, then drain without refill (payload holds)
    tv.push_back(mk(4'b0100, SA, SB, 1'b1, 4'b0100, 1'b1, 8'hAA, 2'd2));
    tv.push_back(mk(4'b0000, SA, SB, 1'b1, 4'b0000, 1'b0, 8'hAA, 2'd2));
    // Backpressure: fill, stall 3 cycles, then drain+refill together
    tv.push_back(mk(4'hF, A, B, 1'b1, 4'b1000, 1'b1, 8'h4B, 2'd3));
    for (int r = 0; r < 3; r++)
      tv.push_back(mk(4'hF, A, B, 1'b0, 4'b0000, 1'b1, 8'h4B, 2'd3));
    tv.push_back(mk(4'hF, A, B, 1'b1, 4'b0001, 1'b1, 8'h1E, 2'd0));
    // Stall with no requests, drain, idle; pointer must not move while idle
    tv.push_back(mk(4'h0, A, B, 1'b0, 4'b0000, 1'b1, 8'h1E, 2'd0));
    tv.push_back(mk(4'h0, A, B, 1'b1, 4'b0000, 1'b0, 8'h1E, 2'd0));
    tv.push_back(mk(4'h0, A, B, 1'b1, 4'b0000, 1'b0, 8'h1E, 2'd0));
    tv.push_back(mk(4'hF, A, B, 1'b1, 4'b0010, 1'b1, 8'h2D, 2'd1));

    // Reset held with all requests pending
    areset_n  = 1'b0;
    req_valid = 4'hF;
    req_a     = A;
    req_b     = B;
    res_ready = 1'b1;
    #12;
    chk("rst_req_ready", 64'(req_ready), 64'h0);
    chk("rst_res_valid", 64'(res_valid), 64'h0);
    chk("rst_res_data",  64'(res_data),  64'h0);
    chk("rst_res_id",    64'(res_id),    64'h0);
    @(negedge clk);
    areset_n  = 1'b1;
    req_valid = 4'h0;

    // Table: drive at negedge, check ready before the edge, result after it
    foreach (tv[i]) begin
      @(negedge clk);
      req_valid = tv[i].v;
      req_a     = tv[i].a;
      req_b     = tv[i].b;
      res_ready = tv[i].rr;
      #1;
      chk($sformatf("v%0d_req_ready", i), 64'(req_ready), 64'(tv[i].er));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_res_valid", i), 64'(res_valid), 64'(tv[i].ev));
      chk($sformatf("v%0d_res_data", i),  64'(res_data),  64'(tv[i].ed));
      chk($sformatf("v%0d_res_id", i),    64'(res_id),    64'(tv[i].eid));
    end

    // Reset mid-operation discards the held result and restarts at requester 0
    @(negedge clk);
    areset_n  = 1'b0;
    req_valid = 4'hF;
    res_ready = 1'b0;
    #1;
    chk("mid_rst_req_ready", 64'(req_ready), 64'h0);
    chk("mid_rst_res_valid", 64'(res_valid), 64'h0);
    chk("mid_rst_res_data",  64'(res_data),  64'h0);
    chk("mid_rst_res_id",    64'(res_id),    64'h0);
    @(posedge clk);
    #1;
    chk("mid_rst_hold_valid", 64'(res_valid), 64'h0);
    @(negedge clk);
    areset_n = 1'b1;
    #1;
    chk("post_rst_req_ready", 64'(req_ready), 64'h1);
    @(posedge clk);
    #1;
    chk("post_rst_res_valid", 64'(res_valid), 64'h1);
    chk("post_rst_res_data",  64'(res_data),  64'h1E);
    chk("post_rst_res_id",    64'(res_id),    64'h0);

`ifdef XOR_SHARE_ARB_STATS_EN
    // Counter saturation on requester 0
    @(negedge clk);
    areset_n  = 1'b0;
    req_valid = 4'h0;
    #1;
    chk("cnt_rst", grant_cnt, 64'h0);
    @(negedge clk);
    areset_n  = 1'b1;
    req_valid = 4'b0001;
    res_ready = 1'b1;
    repeat (70000) @(posedge clk);
    @(negedge clk);
    req_valid = 4'h0;
    #1;
    chk("cnt_lane0_sat", 64'(grant_cnt[15:0]),  64'hFFFF);
    chk("cnt_lanes_123", 64'(grant_cnt[63:16]), 64'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/xor_share_arbiter.md
# xor_share_arbiter

Round-robin arbiter that shares a single registered XOR datapath among `NREQ` requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants one requester per cycle and computes `a ^ b` into an output register. It returns the result tagged with the requester's index over a downstream valid/ready interface. It sits between the per-lane operand sources and the shared XOR unit, and it owns both arbitration and backpressure.

## Interface
Parameters:
- `NREQ`, 4 — number of requesters; legal range 1..16.
- `W`, 8 — operand/result width in bits; must be ≥1.
- `IDW` (localparam) — `max(1, $clog2(NREQ))`.

Ports:
- `clk` in 1 — the single clock; all state updates on its rising edge.
- `areset_n` in 1 — reset, asynchronous and active-low.
- `req_valid` in NREQ — bit i: requester i has an operand pair pending.
- `req_ready` out NREQ — bit i: requester i's pair is accepted this cycle. One-hot or zero.
- `req_a` in NREQ*W — operand A; lane i occupies bits [i*W +: W].
- `req_b` in NREQ*W — operand B; same packing as `req_a`.
- `res_valid` out 1 — the result register holds an unconsumed result.
- `res_ready` in 1 — downstream accepts the result.
- `res_data` out W — `a ^ b` of the granted pair.
- `res_id` out IDW — index of the requester that produced `res_data`.

## Operation
- **Output register states:**
  - EMPTY (`res_valid`=0).
  - FULL (`res_valid`=1).
- **Slot free condition:** the slot is free when EMPTY, or when FULL with `res_ready`=1.
- **Grant:**
  - When the slot is free and any `req_valid` is set, grant exactly one requester i and drive `req_ready[i]`=1.
  - Choose the first set `req_valid` bit searching upward from `rr_ptr`, wrapping from NREQ-1 to 0.
  - `req_ready` is a combinational function of `req_valid`, `rr_ptr` and slot state.
  - `req_ready` never depends on a requester's own `req_ready`.
- **Transfer on grant i:**
  - `res_data` <= `req_a[i] ^ req_b[i]`.
  - `res_id` <= i.
  - `res_valid` <= 1.
  - `rr_ptr` <= (i+1) mod NREQ.
- **Drain without refill:** `res_ready`=1 with no grant gives `res_valid` <= 0. `res_data` and `res_id` hold their last values.
- **Stall:** when FULL and `res_ready`=0, `req_ready` is all zero and all state holds.
- **Pointer movement:** `rr_ptr` moves only on a grant, never on idle cycles.
- **NREQ=1:** `rr_ptr` is constant 0, and the block degenerates to a one-entry registered XOR with handshake.

## Timing
- **Reset values:**
  - `res_valid`=0.
  - `res_data`=0.
  - `res_id`=0.
  - `rr_ptr`=0 (requester 0 has first priority after reset).
  - `req_ready`=0 while `areset_n` is low.
  - Grant counters = 0.
- **Latency:** a pair accepted at edge N appears with `res_valid`=1 after edge N.
- **Throughput:** one result per cycle while `res_ready` stays 1.
- **Simultaneous drain and grant:** the new result replaces the old one in the same edge and `res_valid` stays 1.
- **Upstream hold rule:** requesters must hold `req_valid`, `req_a` and `req_b` stable until `req_ready`. The block does not check this.
- **Downstream hold rule:** while `res_valid`=1 and `res_ready`=0, `res_data` and `res_id` are stable.
- **Reset mid-operation:** an unconsumed result is discarded and no handshake completes in the reset cycle. Operation resumes on the first edge after `areset_n` is released.

## Configuration
- **Macro:** `XOR_SHARE_ARB_STATS_EN`.
- **Defined:**
  - Adds output port `grant_cnt`, NREQ*16 bits.
  - Lane i is a 16-bit saturating count of grants to requester i.
  - Each count increments on every grant and sticks at 16'hFFFF.
  - Counts reset to 0 asynchronously.
- **Undefined:** the port and the counters are absent. Arbitration behaviour is identical in both builds.

## Structure
- **Package `xor_share_pkg`:**
  - `XS_CNT_W` = 16.
  - `XS_CNT_MAX`.
  - Function `xs_idw(n)` returning `max(1, $clog2(n))`.
- **Sub-module `rr_pick`:**
  - Purely combinational.
  - Inputs: request vector and pointer.
  - Outputs: one-hot grant, encoded index, any-grant flag.
  - Instantiated once.

## Test plan
- **Reset:** hold `areset_n`=0 with all `req_valid`=1. Expect `req_ready`=0, `res_valid`=0, `res_data`=0, `res_id`=0. After release, the first grant goes to requester 0.
- **Single lane:** requester 2 only, a=8'hA5, b=8'h0F, `res_ready`=1. Expect `req_ready`=4'b0100 for one cycle. Next cycle `res_valid`=1, `res_data`=8'hAA, `res_id`=2.
- **Fairness:** all four `req_valid` held at 1, `res_ready`=1 for 8 cycles. Expect grant order 0,1,2,3,0,1,2,3 and one result per cycle.
- **Backpressure:** with `res_valid`=1, drop `res_ready` for 3 cycles. Expect `req_ready`=0 and `res_data`/`res_id` stable. Re-asserting `res_ready` drains and refills in the same cycle.
- **Wrap and skip:** last grant to 3, then only requesters 1 and 3 valid. Expect grants 1,3,1,3.
- **Stats (macro on):** 70000 consecutive grants to requester 0. Expect `grant_cnt[15:0]`=16'hFFFF and the other lanes 0.
